// File: rtl/bk_arb_pkg.sv
// Shared types and default sizes for the Brent-Kung adder arbiter.
// Optional signed-overflow output is enabled with BK_ARB_OVF_EN.
package bk_arb_pkg;

    // Response slot occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int BK_N    = 64;
    localparam int BK_NREQ = 4;

endpackage

// File: rtl/Brent_kung_Nbit.sv
// Parameterised combinational Brent-Kung parallel-prefix adder.
// Operands are padded up to a power of two internally so the classic
// up-sweep / down-sweep prefix tree applies for any width.
import bk_arb_pkg::*;

module Brent_kung_Nbit #(
    parameter int N = BK_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int M = 1 << $clog2(N);

    logic [M-1:0] gg;
    logic [M-1:0] pp;
    logic [N-1:0] p;

    assign p = a ^ b;

    // Prefix tree: gg[i] ends up as the carry out of bit i (cin folded into bit 0)
    always_comb begin
        gg        = '0;
        pp        = '0;
        sum       = '0;
        gg[N-1:0] = a & b;
        pp[N-1:0] = p;
        gg[0]     = gg[0] | (pp[0] & cin);
        for (int d = 1; d < M; d = d * 2) begin
            for (int i = 2 * d - 1; i < M; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        for (int d = M / 4; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < M; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        sum[0] = p[0] ^ cin;
        for (int i = 1; i < N; i++) begin
            sum[i] = p[i] ^ gg[i-1];
        end
    end

    assign cout = gg[N-1];

endmodule

// File: rtl/bk_adder_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches last+1, last+2, ... cyclically and grants
// the first asserted request. Grant is one-hot or zero; zero when disabled.
import bk_arb_pkg::*;

module rr_arbiter #(
    parameter int NREQ = BK_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    int   cand;
    logic found;

    // Cyclic priority search starting just after the last winner
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last) + k) % NREQ;
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/bk_adder_arbiter.sv
// Shares one Brent-Kung adder among NREQ requesters with round-robin
// arbitration and a single registered response slot (1-cycle latency,
// full throughput when the consumer drains every cycle).
// Define BK_ARB_OVF_EN to add the registered signed-overflow output rsp_ovf.
import bk_arb_pkg::*;

module bk_adder_arbiter #(
    parameter int N    = BK_N,
    parameter int NREQ = BK_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ-1:0] req_cin,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IDW-1:0]  rsp_id,
    output logic [N-1:0]    rsp_sum,
    output logic            rsp_cout
`ifdef BK_ARB_OVF_EN
    ,
    output logic            rsp_ovf
`endif
);

    state_t          state;
    logic [IDW-1:0]  last;
    logic            free;
    logic            en;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    logic            accept;
    logic [N-1:0]    add_a;
    logic [N-1:0]    add_b;
    logic            add_cin;
    logic [N-1:0]    add_sum;
    logic            add_cout;

    // Slot can take a new result if empty or being drained this cycle;
    // grants are suppressed while reset is held.
    assign free      = (state == EMPTY) || rsp_ready;
    assign en        = free && rst_n;
    assign req_ready = grant;
    assign accept    = |grant;
    assign rsp_valid = (state == FULL);

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .last  (last),
        .en    (en),
        .grant (grant),
        .idx   (gidx)
    );

    // Steer the winner's operands into the adder; idle inputs are zero
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (accept) begin
            add_a   = req_a[int'(gidx)*N +: N];
            add_b   = req_b[int'(gidx)*N +: N];
            add_cin = req_cin[gidx];
        end
    end

    Brent_kung_Nbit #(
        .N (N)
    ) u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

`ifdef BK_ARB_OVF_EN
    logic signed [N-1:0] sa;
    logic signed [N-1:0] ss;
    logic                add_ovf;
    assign sa      = add_a;
    assign ss      = add_sum;
    assign add_ovf = (add_a[N-1] == add_b[N-1]) && ((ss < 0) != (sa < 0));
`endif

    // Response slot FSM, RR pointer and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            last     <= IDW'(NREQ - 1);
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
`ifdef BK_ARB_OVF_EN
            rsp_ovf  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                state    <= FULL;
                last     <= gidx;
                rsp_id   <= gidx;
                rsp_sum  <= add_sum;
                rsp_cout <= add_cout;
`ifdef BK_ARB_OVF_EN
                rsp_ovf  <= add_ovf;
`endif
            end else if (state == FULL && rsp_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule
